// File: rtl/ntt_rom_loader.sv
// Packs 12-bit NTT coefficients eight at a time into 96-bit words for the coefficient ROM.
// Optional mod-q reduction of each input is compiled in with `define NTT_LOADER_REDUCE_EN.
`timescale 1ns/1ps

module ntt_rom_loader #(
  parameter int unsigned COEF_W = 12,
  parameter int unsigned LANES  = 8,
  parameter int unsigned WORDS  = 32,
  parameter int unsigned Q      = 3329
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       start,
  input  logic [COEF_W-1:0]          in_coef,
  input  logic                       in_valid,
  output logic                       in_ready,
  output logic [COEF_W*LANES-1:0]    wdata,
  output logic [$clog2(WORDS)-1:0]   wdata_addr,
  output logic                       busy,
  output logic                       done
);

  localparam int unsigned WORD_W = COEF_W * LANES;
  localparam int unsigned ADDR_W = $clog2(WORDS);
  localparam int unsigned LANE_W = $clog2(LANES);
  localparam int unsigned CNT_W  = ADDR_W + LANE_W;
  localparam int unsigned PACK_W = COEF_W * (LANES - 1);

  // Reject configurations the ROM word layout cannot represent.
  if (WORD_W != 96 || (1 << LANE_W) != LANES || Q >= (1 << COEF_W)) begin : g_bad_cfg
    $error("ntt_rom_loader: unsupported COEF_W/LANES/Q combination");
  end

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t              state;
  logic [CNT_W-1:0]    cnt;
  logic [PACK_W-1:0]   pack;
  logic [COEF_W-1:0]   coef_val;
  logic [LANE_W-1:0]   lane;
  logic [ADDR_W-1:0]   word_idx;
  logic                last_lane;
  logic                last_coef;
  logic                accept;

  assign lane      = cnt[LANE_W-1:0];
  assign word_idx  = cnt[CNT_W-1:LANE_W];
  assign last_lane = (lane == LANE_W'(LANES - 1));
  assign last_coef = (cnt == {CNT_W{1'b1}});
  assign accept    = in_valid && in_ready;

  // Single conditional subtract brings 0..4095 into 0..q-1 when reduction is built in.
  always_comb begin
    coef_val = in_coef;
`ifdef NTT_LOADER_REDUCE_EN
    if (in_coef >= COEF_W'(Q)) begin
      coef_val = in_coef - COEF_W'(Q);
    end
`endif
  end

  // Control FSM with packing datapath; wdata/wdata_addr only move on a lane-7 accept.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= S_IDLE;
      cnt        <= '0;
      pack       <= '0;
      wdata      <= '0;
      wdata_addr <= '0;
      in_ready   <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
    end else begin
      case (state)
        S_IDLE, S_DONE: begin
          if (start) begin
            state    <= S_LOAD;
            cnt      <= '0;
            pack     <= '0;
            in_ready <= 1'b1;
            busy     <= 1'b1;
            done     <= 1'b0;
          end
        end
        S_LOAD: begin
          if (accept) begin
            cnt <= cnt + CNT_W'(1);
            for (int unsigned k = 0; k < LANES - 1; k++) begin
              if (lane == LANE_W'(k)) begin
                pack[k*COEF_W +: COEF_W] <= coef_val;
              end
            end
            if (last_lane) begin
              wdata      <= {coef_val, pack};
              wdata_addr <= word_idx;
            end
            if (last_coef) begin
              state    <= S_DONE;
              in_ready <= 1'b0;
              busy     <= 1'b0;
              done     <= 1'b1;
            end
          end
        end
        default: begin
          state    <= S_IDLE;
          in_ready <= 1'b0;
          busy     <= 1'b0;
          done     <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ntt_rom_loader.sv
// Scoreboard bench for ntt_rom_loader with a behavioural model of the always-writing ROM.
`timescale 1ns/1ps

module tb_ntt_rom_loader;

  localparam int unsigned COEF_W = 12;
  localparam int unsigned LANES  = 8;
  localparam int unsigned WORDS  = 32;
  localparam int unsigned WORD_W = 96;
  localparam int unsigned ADDR_W = 5;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              start = 1'b0;
  logic [COEF_W-1:0] in_coef = '0;
  logic              in_valid = 1'b0;
  logic              in_ready;
  logic [WORD_W-1:0] wdata;
  logic [ADDR_W-1:0] wdata_addr;
  logic              busy;
  logic              done;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [WORD_W-1:0] data;
  } commit_t;

  commit_t           sb_q[$];
  logic [WORD_W-1:0] rom     [WORDS];
  logic [WORD_W-1:0] exp_rom [WORDS];
  logic [COEF_W-1:0] stim    [256];
  int                n_checks = 0;
  int                n_fail = 0;

  ntt_rom_loader #(
    .COEF_W(COEF_W), .LANES(LANES), .WORDS(WORDS), .Q(3329)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .in_coef(in_coef), .in_valid(in_valid),
    .in_ready(in_ready), .wdata(wdata), .wdata_addr(wdata_addr), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [WORD_W-1:0] act, input logic [WORD_W-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  function automatic logic [COEF_W-1:0] reduce(input logic [COEF_W-1:0] x);
`ifdef NTT_LOADER_REDUCE_EN
    return (x >= 12'd3329) ? x - 12'd3329 : x;
`else
    return x;
`endif
  endfunction

  // ROM writes every cycle; reset clears it.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < WORDS; i++) rom[i] <= '0;
    end else begin
      rom[wdata_addr] <= wdata;
    end
  end

  // Cycle model of the handshake; compares outputs #1 after every edge.
  int                m_state = 0;
  int                m_cnt = 0;
  bit                commit_now;
  logic [WORD_W-1:0] last_data = '0;
  logic [ADDR_W-1:0] last_addr = '0;

  always @(posedge clk) begin : monitor
    commit_t e;
    commit_now = 1'b0;
    if (rst) begin
      m_state   = 0;
      m_cnt     = 0;
      last_data = '0;
      last_addr = '0;
      sb_q.delete();
    end else begin
      case (m_state)
        0, 2: if (start) begin m_state = 1; m_cnt = 0; end
        1: if (in_valid) begin
          commit_now = (m_cnt % 8 == 7);
          if (m_cnt == 255) m_state = 2;
          m_cnt++;
        end
        default: ;
      endcase
    end
    #1;
    if (!rst) begin
      check("in_ready", in_ready, m_state == 1);
      check("busy", busy, m_state == 1);
      check("done", done, m_state == 2);
      if (commit_now) begin
        if (sb_q.size() == 0) begin
          check("sb_underflow", 1'b1, 1'b0);
        end else begin
          e = sb_q.pop_front();
          last_data = e.data;
          last_addr = e.addr;
        end
        check("commit_data", wdata, last_data);
        check("commit_addr", wdata_addr, last_addr);
      end else begin
        check("hold_data", wdata, last_data);
        check("hold_addr", wdata_addr, last_addr);
      end
    end
  end

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    start = 1'b0;
    in_valid = 1'b0;
    #1;
    check("rst_in_ready", in_ready, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_wdata", wdata, '0);
    check("rst_addr", wdata_addr, '0);
    for (int i = 0; i < WORDS; i++) exp_rom[i] = '0;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic do_start();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Drives n coefficients from stim at negedges; gap is the percent chance of an idle cycle.
  task automatic feed(input int n, input int gap, input int start_at);
    logic [WORD_W-1:0] cur_word;
    commit_t e;
    cur_word = '0;
    for (int i = 0; i < n; i++) begin
      while (gap > 0 && int'($urandom_range(0, 99)) < gap) begin
        in_valid = 1'b0;
        start = 1'b0;
        @(negedge clk);
      end
      in_valid = 1'b1;
      in_coef = stim[i];
      start = (i == start_at);
      cur_word[(i % 8) * COEF_W +: COEF_W] = reduce(stim[i]);
      if (i % 8 == 7) begin
        e.addr = ADDR_W'(i / 8);
        e.data = cur_word;
        sb_q.push_back(e);
        exp_rom[i / 8] = cur_word;
      end
      @(negedge clk);
    end
    in_valid = 1'b0;
    start = 1'b0;
  endtask

  task automatic check_rom(input string tag);
    for (int m = 0; m < WORDS; m++) check($sformatf("%s_rom%0d", tag, m), rom[m], exp_rom[m]);
  endtask

  initial begin
    do_reset();

    // in_valid while idle must not be accepted
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      in_valid = 1'b1;
      in_coef = 12'hABC;
    end
    @(negedge clk);
    in_valid = 1'b0;

    for (int i = 0; i < 256; i++) stim[i] = 12'(i);
    do_start();
    feed(256, 0, 40);
    repeat (3) @(negedge clk);
    check_rom("gapless");
    check("word0_gapless", rom[0], 96'h007006005004003002001000);
    repeat (5) @(negedge clk);

    do_start();
    feed(256, 40, -1);
    repeat (3) @(negedge clk);
    check_rom("gapped");
    check("word0_gapped", rom[0], 96'h007006005004003002001000);
    check("word31_gapped", rom[31], 96'h0ff0fe0fd0fc0fb0fa0f90f8);

    for (int i = 0; i < 256; i++) stim[i] = 12'($urandom);
    stim[0] = 12'd4095;
    stim[1] = 12'd3329;
    do_start();
    feed(256, 25, -1);
    repeat (3) @(negedge clk);
    check_rom("reduce");
`ifdef NTT_LOADER_REDUCE_EN
    check("lane_4095", rom[0][11:0], 12'd766);
    check("lane_3329", rom[0][23:12], 12'd0);
`else
    check("lane_4095", rom[0][11:0], 12'd4095);
    check("lane_3329", rom[0][23:12], 12'd3329);
`endif

    for (int i = 0; i < 256; i++) stim[i] = 12'($urandom);
    do_start();
    feed(100, 10, -1);
    do_reset();
    check("rom_cleared", rom[0], '0);
    do_start();
    feed(256, 0, -1);
    repeat (3) @(negedge clk);
    check_rom("after_rst");
    check("sb_drained", 96'(sb_q.size()), '0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/ntt_rom_loader.md
# ntt_rom_loader

Upstream feeder for the 32×96-bit NTT coefficient ROM. Accepts one 12-bit coefficient per valid/ready handshake, optionally reduces it mod q = 3329, and packs eight consecutive coefficients into a 96-bit word. Full words are presented on the ROM's `wdata`/`wdata_addr` port. The ROM writes unconditionally every cycle, so between commits this block holds the last committed word and address stable; the repeated write is idempotent.

## Interface
- `COEF_W`, 12: coefficient width in bits.
- `LANES`, 8: coefficients per ROM word. `COEF_W*LANES` must equal 96.
- `WORDS`, 32: ROM depth. Address width is 5.
- `Q`, 3329: modulus, used only when the reduction feature is compiled in.
- `clk`  in  1: single clock, rising edge.
- `rst`  in  1: asynchronous, active-high reset.
- `start`  in  1: one-cycle pulse that begins a 256-coefficient load.
- `in_coef`  in  12: input coefficient.
- `in_valid`  in  1: `in_coef` is valid.
- `in_ready`  out  1: block accepts a coefficient this cycle.
- `wdata`  out  96: packed word driven to the ROM.
- `wdata_addr`  out  5: ROM word address.
- `busy`  out  1: load in progress.
- `done`  out  1: all 32 words committed. Held until the next `start`.

## Operation
- FSM states: IDLE, LOAD, DONE.
  - IDLE → LOAD on `start`.
  - LOAD → DONE on the edge that accepts coefficient 255.
  - DONE → LOAD on `start`.
  - `start` in LOAD is ignored.
- Counter `cnt[7:0]` is cleared on entry to LOAD. It increments on each accept (`in_valid && in_ready`).
  - Lane = `cnt[2:0]`.
  - Word index = `cnt[7:3]`.
- Packing register `pack[83:0]` holds lanes 0–6. The coefficient with lane k occupies bits `[12k+11:12k]`, so coefficient 0 of a word is in the LSBs.
- Commit happens on the accept of lane 7:
  - `wdata <= {c7, pack[83:0]}`
  - `wdata_addr <= cnt[7:3]`
  - No other edge changes `wdata` or `wdata_addr`.
- Coefficient value c:
  - With the reduction feature: `c = (in_coef >= Q) ? in_coef - Q : in_coef`.
  - Without it: `c = in_coef`.
- `in_ready = (state == LOAD)`, decoded from the state register with no combinational path from `in_valid`.
- `busy = (state == LOAD)`. `done = (state == DONE)`.
- Stalls: `in_valid` low in LOAD holds `cnt`, `pack` and the outputs unchanged. There is no timeout.
- Restart from DONE: `cnt` and `pack` are cleared. `wdata` and `wdata_addr` keep word 31 until the first new commit.
- Reset mid-load clears the FSM, `cnt`, `pack` and all outputs; the ROM's reset clears its contents. A new `start` is required.

## Timing
- Reset values: `in_ready` = 0, `wdata` = 0, `wdata_addr` = 0, `busy` = 0, `done` = 0, state = IDLE. Writing 0 to address 0 matches the ROM's reset contents.
- `start` at edge N puts the block in LOAD after edge N; `in_ready` = 1 from cycle N+1.
- Commit latency:
  - The accept of lane 7 at edge E makes `wdata`/`wdata_addr` visible after E.
  - The ROM captures the word at edge E+1.
  - A ROM read of the same address in cycle E+1 returns the new data through the ROM bypass.
- `done` rises after the edge accepting coefficient 255, in the same cycle word 31 is presented. Word 31 is stored in the ROM one edge later.
- Maximum throughput is 1 coefficient per cycle, so a full load takes a minimum of 256 cycles from the first `in_ready`.

## Configuration
- `NTT_LOADER_REDUCE_EN` defined: compares each coefficient against Q and subtracts once. Inputs 3329–4095 map to 0–766.
- Not defined: coefficients pass through unmodified and the compare/subtract logic is absent.
- Handshake, timing and latency are identical in both builds.

## Test plan
- Reset then idle: all outputs 0, `in_ready` = 0; `in_valid` pulses are not accepted, `cnt` stays 0.
- `start`, then feed 0..255 continuously:
  - Word m = lanes `{8m+7, …, 8m}`; word 0 = `{12'd7, …, 12'd0}`.
  - Each commit occurs 1 cycle after the lane-7 accept.
  - `done` = 1 after the 256th accept; ROM reads of all 32 words match.
- Random `in_valid` gaps:
  - `wdata`/`wdata_addr` stay constant between commits.
  - ROM contents are unchanged by the held writes; final contents equal the gapless run.
- Feed 4095 and 3329:
  - With the macro: lanes read 766 and 0.
  - Without the macro: lanes read 4095 and 3329.
- `rst` asserted after 100 accepts: outputs, `busy` and `done` go to 0 immediately. A new `start` plus 256 coefficients completes correctly.
- `start` during LOAD is ignored (count continues). `start` in DONE clears `done` and begins a new load.
